sam_mc6883: RTL and testbench
=============================

Name: sam_mc6883

Overview:
- Parametrised synchronous address multiplexer (SAM) for the CoCo2 core. Successor to the simplified SAM.
- Generates the E/Q CPU clocks and the VDG pixel clock enable from the system clock.
- Decodes CPU addresses into the 3-bit S device select, drives the RAM address with page and map-type handling, and holds the full $FFC0-$FFDF set/clear register file.
- Runs a VDG video address counter with display offset and per-mode row repeat, replacing the adder currently done at top level.

Parameters:
- E_DIV, 16, clk cycles per E period; must be a multiple of 4 and at least 8.
- VCLK_DIV, 14, clk cycles per vclk_en pulse; at least 2.
- RAM_AW, 16, RAM address width; 15 or 16.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  16  CPU address bus.
- cpu_rw  in  1  CPU read/not-write.
- E  out  1  CPU E clock.
- Q  out  1  CPU Q clock; leads E by a quarter period.
- vclk_en  out  1  one-clk pulse every VCLK_DIV cycles, clock enable for the VDG.
- S  out  3  device select for the 74138 decode.
- ram_addr  out  RAM_AW  CPU-side RAM address.
- vid_fetch  in  1  one-clk pulse: VDG consumed one byte.
- vdg_hs_n  in  1  VDG horizontal sync, active low.
- vdg_fs_n  in  1  VDG field sync, active low.
- vid_addr  out  16  video RAM address.
- mode_v  out  3  V register.
- rate  out  2  R register (stored only).
- mem_size  out  2  M register (stored only).

Behaviour:
- Reset (async, active-high): phase counter=0, E=0, Q=0, vclk_en=0, all register bits=0, vid_addr=0, row start=0, row count=0. S and ram_addr are combinational on cpu_addr, so with registers at 0 they reflect TY=0 decode.
- E/Q phase counter: counts 0..E_DIV-1 and wraps.
  - Q=1 for phase in [E_DIV/4, 3*E_DIV/4).
  - E=1 for phase in [E_DIV/2, E_DIV).
  - Both are registered; no glitches.
- vclk_en: separate counter 0..VCLK_DIV-1; pulses high for one clk on terminal count. Independent of E.
- Register file: 16 bits.
  - Bit index = cpu_addr[4:1]; value = cpu_addr[0]. For example, $FFC0 clears bit 0 and $FFC1 sets bit 0.
  - Bit map: 0-2 V, 3-9 F (display offset, bit 3 = F0), 10 P1, 11-12 R, 13-14 M, 15 TY.
  - A write commits on the clk where E goes 1->0 with cpu_rw=0 and cpu_addr in $FFC0-$FFDF. Only one bit changes per write.
  - Registers are write-only. Reads of this range give S=7.
- S decode, TY=0:
  - $0000-7FFF -> 0
  - $8000-9FFF -> 1
  - $A000-BFFF -> 2
  - $C000-FEFF -> 3
  - $FF00-FF1F -> 4
  - $FF20-FF3F -> 5
  - $FF40-FF5F -> 6
  - $FF60-FFDF -> 7
  - $FFE0-FFFF -> 2 (vectors come from BASIC ROM at offset $1FE0-1FFF)
- S decode, TY=1: $0000-FEFF -> 0. $FF00-FFFF decodes as in TY=0.
- ram_addr = cpu_addr[RAM_AW-1:0]. When RAM_AW=16, TY=0 and cpu_addr[15]=0, bit 15 is replaced by P1.
- Video counter: vid_addr is a 16-bit wrapping counter.
  - vdg_fs_n low (level): vid_addr = row_start = {F,9'b0}; row_cnt=0. Field sync has priority over all other video events.
  - vid_fetch pulse: vid_addr += 1.
  - vdg_hs_n falling edge (sampled 1->0 in clk): if row_cnt < REP(V)-1, then vid_addr=row_start and row_cnt+=1. Otherwise row_start=vid_addr and row_cnt=0.
  - REP(V) for V=0..7: 1, 3, 3, 2, 2, 1, 1, 1.
  - vid_fetch and an hs edge in the same clk: the hs action applies to the incremented address. Row start commits addr+1; a rewind ignores the fetch.
  - A change of V mid-row takes effect at the next hs edge. If row_cnt >= new REP-1, the row commits.

Test Plan:
- Reset, then free-run 64 clks, E_DIV=16 -> Q rises at phase 4 and falls at 12; E rises at 8 and falls at 0; period 16. vclk_en pulses every 14 clks.
- Write sequence $FFC7,$FFC9,$FFCB,$FFCD (E falling, rw=0) -> F=7'h0F. Assert fs_n low -> vid_addr=$1E00.
- TY=0: cpu_addr $0123 -> S=0. $9FFF -> 1. $FFFE -> 2. $FF22 -> 5. $FFD0 -> 7. Set TY ($FFDF), then $C000 -> S=0, and $FF02 -> 4.
- V=1 (write $FFC1): 32 fetches then hs edge, three times -> vid_addr returns to row start twice. The third edge commits row start at +32.
- P1 set ($FFD5), RAM_AW=16: cpu_addr $1234 -> ram_addr $9234. With TY=1, $1234 -> $1234.
- Assert reset mid-field while vid_addr=$0450, E=1 -> all outputs cleared within the same cycle, registers 0, S decode reverts to TY=0.

Source files
------------

// File: rtl/sam_mc6883.sv
// MC6883 SAM: E/Q clocks, VDG clock enable, device select, RAM address mapping,
// the $FFC0-$FFDF set/clear register file and the VDG video address counter.
module sam_mc6883 #(
    parameter int unsigned E_DIV    = 16,
    parameter int unsigned VCLK_DIV = 14,
    parameter int unsigned RAM_AW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_rw,
    output logic              E,
    output logic              Q,
    output logic              vclk_en,
    output logic [2:0]        S,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic              vid_fetch,
    input  logic              vdg_hs_n,
    input  logic              vdg_fs_n,
    output logic [15:0]       vid_addr,
    output logic [2:0]        mode_v,
    output logic [1:0]        rate,
    output logic [1:0]        mem_size
);

    localparam int unsigned PW = $clog2(E_DIV);
    localparam int unsigned VW = (VCLK_DIV > 2) ? $clog2(VCLK_DIV) : 1;

    logic [PW-1:0] phase_q, phase_d;
    logic          e_q, e_d, q_q, q_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          vclk_q, vclk_d;
    logic [15:0]   regs_q, regs_d;
    logic          reg_wr;
    logic [15:0]   vid_q, vid_d, vid_inc;
    logic [15:0]   row_start_q, row_start_d;
    logic [1:0]    row_cnt_q, row_cnt_d;
    logic [1:0]    rep_m1;
    logic          hs_prev_q, hs_fall;
    logic [6:0]    f_off;
    logic          p1, ty;

    assign mode_v   = regs_q[2:0];
    assign f_off    = regs_q[9:3];
    assign p1       = regs_q[10];
    assign rate     = regs_q[12:11];
    assign mem_size = regs_q[14:13];
    assign ty       = regs_q[15];

    assign E        = e_q;
    assign Q        = q_q;
    assign vclk_en  = vclk_q;
    assign vid_addr = vid_q;

    // E/Q are decoded from the next phase so the registered outputs line up with phase_q.
    always_comb begin
        phase_d = (phase_q == PW'(E_DIV - 1)) ? '0 : phase_q + 1'b1;
        q_d     = (phase_d >= PW'(E_DIV / 4)) && (phase_d < PW'(3 * E_DIV / 4));
        e_d     = (phase_d >= PW'(E_DIV / 2));
        vcnt_d  = (vcnt_q == VW'(VCLK_DIV - 1)) ? '0 : vcnt_q + 1'b1;
        vclk_d  = (vcnt_d == VW'(VCLK_DIV - 1));
    end

    assign reg_wr = e_q && !e_d && !cpu_rw && (cpu_addr[15:5] == 11'b111_1111_1110);

    always_comb begin
        regs_d = regs_q;
        if (reg_wr) begin
            regs_d[cpu_addr[4:1]] = cpu_addr[0];
        end
    end

    always_comb begin
        S = 3'd0;
        if (cpu_addr[15:8] == 8'hFF) begin
            unique case (cpu_addr[7:5])
                3'd0:    S = 3'd4;
                3'd1:    S = 3'd5;
                3'd2:    S = 3'd6;
                3'd7:    S = 3'd2;
                default: S = 3'd7;
            endcase
        end else if (!ty) begin
            unique case (cpu_addr[15:13])
                3'b100:  S = 3'd1;
                3'b101:  S = 3'd2;
                3'b110,
                3'b111:  S = 3'd3;
                default: S = 3'd0;
            endcase
        end
    end

    generate
        if (RAM_AW == 16) begin : g_ram16
            assign ram_addr = (!ty && !cpu_addr[15]) ? {p1, cpu_addr[14:0]} : cpu_addr;
        end else begin : g_ram15
            assign ram_addr = cpu_addr[RAM_AW-1:0];
        end
    endgenerate

    always_comb begin
        unique case (mode_v)
            3'd1, 3'd2: rep_m1 = 2'd2;
            3'd3, 3'd4: rep_m1 = 2'd1;
            default:    rep_m1 = 2'd0;
        endcase
    end

    assign hs_fall = hs_prev_q && !vdg_hs_n;
    assign vid_inc = vid_fetch ? vid_q + 16'd1 : vid_q;

    // A fetch coinciding with an hs edge is folded into the committed row start, dropped on rewind.
    always_comb begin
        vid_d       = vid_inc;
        row_start_d = row_start_q;
        row_cnt_d   = row_cnt_q;
        if (!vdg_fs_n) begin
            vid_d       = {f_off, 9'b0};
            row_start_d = {f_off, 9'b0};
            row_cnt_d   = '0;
        end else if (hs_fall) begin
            if (row_cnt_q < rep_m1) begin
                vid_d     = row_start_q;
                row_cnt_d = row_cnt_q + 2'd1;
            end else begin
                row_start_d = vid_inc;
                row_cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            e_q         <= 1'b0;
            q_q         <= 1'b0;
            vcnt_q      <= '0;
            vclk_q      <= 1'b0;
            regs_q      <= '0;
            vid_q       <= '0;
            row_start_q <= '0;
            row_cnt_q   <= '0;
            hs_prev_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            e_q         <= e_d;
            q_q         <= q_d;
            vcnt_q      <= vcnt_d;
            vclk_q      <= vclk_d;
            regs_q      <= regs_d;
            vid_q       <= vid_d;
            row_start_q <= row_start_d;
            row_cnt_q   <= row_cnt_d;
            hs_prev_q   <= vdg_hs_n;
        end
    end

endmodule

// File: tb/tb_sam_mc6883.sv
// Directed bench for sam_mc6883: clock phases, decode table, register writes,
// video row repeat corners and asynchronous reset.
module tb_sam_mc6883;

    localparam int unsigned EDIV = 16;
    localparam int unsigned VDIV = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rw = 1'b1;
    logic        E, Q, vclk_en;
    logic [2:0]  S;
    logic [15:0] ram_addr;
    logic        vid_fetch = 1'b0;
    logic        vdg_hs_n = 1'b1;
    logic        vdg_fs_n = 1'b1;
    logic [15:0] vid_addr;
    logic [2:0]  mode_v;
    logic [1:0]  rate, mem_size;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [15:0] addr;
        logic        ty;
        logic        p1;
        logic [2:0]  s;
        logic [15:0] ram;
    } dvec_t;

    dvec_t tbl[$];
    logic  cur_ty = 1'b0;
    logic  cur_p1 = 1'b0;

    sam_mc6883 #(.E_DIV(EDIV), .VCLK_DIV(VDIV), .RAM_AW(16)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .E(E), .Q(Q), .vclk_en(vclk_en), .S(S), .ram_addr(ram_addr),
        .vid_fetch(vid_fetch), .vdg_hs_n(vdg_hs_n), .vdg_fs_n(vdg_fs_n),
        .vid_addr(vid_addr), .mode_v(mode_v), .rate(rate), .mem_size(mem_size)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_e(input logic lvl);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (E !== lvl && n < 100);
        if (E !== lvl) chk("E_wait_timeout", E, lvl);
    endtask

    task automatic write_reg(input logic [15:0] a);
        cpu_addr = a;
        cpu_rw   = 1'b0;
        wait_e(1'b1);
        wait_e(1'b0);
        cpu_rw   = 1'b1;
        cpu_addr = 16'h0000;
    endtask

    task automatic fetch_n(input int n);
        repeat (n) begin
            @(negedge clk); vid_fetch = 1'b1;
            @(negedge clk); vid_fetch = 1'b0;
        end
    endtask

    task automatic hs_edge(input logic with_fetch);
        @(negedge clk); vdg_hs_n = 1'b0; vid_fetch = with_fetch;
        @(negedge clk); vdg_hs_n = 1'b1; vid_fetch = 1'b0;
        @(negedge clk);
    endtask

    task automatic fs_pulse();
        @(negedge clk); vdg_fs_n = 1'b0;
        @(negedge clk); vdg_fs_n = 1'b1;
    endtask

    function automatic dvec_t mk(input logic [15:0] a, input logic ty, input logic p1,
                                 input logic [2:0] s, input logic [15:0] ram);
        dvec_t v;
        v.addr = a; v.ty = ty; v.p1 = p1; v.s = s; v.ram = ram;
        return v;
    endfunction

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (tbl[i].p1 !== cur_p1) begin
                write_reg({15'h7FEA, tbl[i].p1});
                cur_p1 = tbl[i].p1;
            end
            if (tbl[i].ty !== cur_ty) begin
                write_reg({15'h7FEF, tbl[i].ty});
                cur_ty = tbl[i].ty;
            end
            @(negedge clk);
            cpu_addr = tbl[i].addr;
            #1;
            chk($sformatf("S@%h", tbl[i].addr), S, tbl[i].s);
            chk($sformatf("ram@%h", tbl[i].addr), ram_addr, tbl[i].ram);
        end
    endtask

    initial begin
        // TY=0, P1=0
        tbl.push_back(mk(16'h0123, 0, 0, 3'd0, 16'h0123));
        tbl.push_back(mk(16'h7FFF, 0, 0, 3'd0, 16'h7FFF));
        tbl.push_back(mk(16'h8000, 0, 0, 3'd1, 16'h8000));
        tbl.push_back(mk(16'h9FFF, 0, 0, 3'd1, 16'h9FFF));
        tbl.push_back(mk(16'hA000, 0, 0, 3'd2, 16'hA000));
        tbl.push_back(mk(16'hBFFF, 0, 0, 3'd2, 16'hBFFF));
        tbl.push_back(mk(16'hC000, 0, 0, 3'd3, 16'hC000));
        tbl.push_back(mk(16'hFEFF, 0, 0, 3'd3, 16'hFEFF));
        tbl.push_back(mk(16'hFF00, 0, 0, 3'd4, 16'hFF00));
        tbl.push_back(mk(16'hFF1F, 0, 0, 3'd4, 16'hFF1F));
        tbl.push_back(mk(16'hFF20, 0, 0, 3'd5, 16'hFF20));
        tbl.push_back(mk(16'hFF22, 0, 0, 3'd5, 16'hFF22));
        tbl.push_back(mk(16'hFF40, 0, 0, 3'd6, 16'hFF40));
        tbl.push_back(mk(16'hFF5F, 0, 0, 3'd6, 16'hFF5F));
        tbl.push_back(mk(16'hFF60, 0, 0, 3'd7, 16'hFF60));
        tbl.push_back(mk(16'hFFD0, 0, 0, 3'd7, 16'hFFD0));
        tbl.push_back(mk(16'hFFDF, 0, 0, 3'd7, 16'hFFDF));
        tbl.push_back(mk(16'hFFE0, 0, 0, 3'd2, 16'hFFE0));
        tbl.push_back(mk(16'hFFFE, 0, 0, 3'd2, 16'hFFFE));
        // P1 set: low half maps to upper 32K page
        tbl.push_back(mk(16'h1234, 0, 1, 3'd0, 16'h9234));
        tbl.push_back(mk(16'h9234, 0, 1, 3'd1, 16'h9234));
        // TY set: flat RAM below $FF00, no paging
        tbl.push_back(mk(16'h1234, 1, 1, 3'd0, 16'h1234));
        tbl.push_back(mk(16'hC000, 1, 1, 3'd0, 16'hC000));
        tbl.push_back(mk(16'hFEFF, 1, 1, 3'd0, 16'hFEFF));
        tbl.push_back(mk(16'hFF02, 1, 1, 3'd4, 16'hFF02));
        tbl.push_back(mk(16'hFFE0, 1, 1, 3'd2, 16'hFFE0));

        #1;
        chk("rst_E", E, 0);
        chk("rst_Q", Q, 0);
        chk("rst_vclk", vclk_en, 0);
        chk("rst_vid", vid_addr, 16'h0000);
        chk("rst_v", mode_v, 0);
        chk("rst_rate", rate, 0);
        chk("rst_msize", mem_size, 0);
        chk("rst_S", S, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            chk($sformatf("E_k%0d", k), E, ((k % EDIV) >= EDIV / 2));
            chk($sformatf("Q_k%0d", k), Q, ((k % EDIV) >= EDIV / 4) && ((k % EDIV) < 3 * EDIV / 4));
            chk($sformatf("vclk_k%0d", k), vclk_en, ((k % VDIV) == VDIV - 1));
        end

        run_table(0, 19);

        write_reg(16'hFFC7);
        write_reg(16'hFFC9);
        write_reg(16'hFFCB);
        write_reg(16'hFFCD);
        write_reg(16'hFFD7);
        write_reg(16'hFFDB);
        chk("v_after_F", mode_v, 0);
        chk("rate", rate, 2'd1);
        chk("msize", mem_size, 2'd1);
        fs_pulse();
        chk("fs_F0F", vid_addr, 16'h1E00);

        write_reg(16'hFFC1);
        chk("v1", mode_v, 3'd1);
        fetch_n(32);
        chk("fetch32", vid_addr, 16'h1E20);
        hs_edge(0);
        chk("hs1_rewind", vid_addr, 16'h1E00);
        fetch_n(32);
        hs_edge(0);
        chk("hs2_rewind", vid_addr, 16'h1E00);
        fetch_n(32);
        hs_edge(0);
        chk("hs3_commit", vid_addr, 16'h1E20);
        fetch_n(32);
        hs_edge(0);
        chk("hs4_rewind_new", vid_addr, 16'h1E20);

        // V->0 mid-row with row_cnt=1: next edge commits, including the coincident fetch
        write_reg(16'hFFC0);
        fetch_n(5);
        hs_edge(1);
        chk("v0_commit_fetch", vid_addr, 16'h1E26);
        write_reg(16'hFFC1);
        write_reg(16'hFFC3);
        chk("v3", mode_v, 3'd3);
        fetch_n(4);
        hs_edge(1);
        chk("v3_rewind_fetch", vid_addr, 16'h1E26);

        run_table(19, tbl.size());

        write_reg(16'hFFC6);
        write_reg(16'hFFC8);
        write_reg(16'hFFCA);
        write_reg(16'hFFCC);
        write_reg(16'hFFC9);
        fs_pulse();
        chk("fs_F02", vid_addr, 16'h0400);
        fetch_n(80);
        chk("vid_0450", vid_addr, 16'h0450);

        wait_e(1'b1);
        cpu_addr = 16'hC000;
        #1;
        chk("pre_rst_E", E, 1);
        chk("pre_rst_S_ty1", S, 3'd0);
        #1 reset = 1'b1;
        #1;
        chk("mrst_E", E, 0);
        chk("mrst_Q", Q, 0);
        chk("mrst_vclk", vclk_en, 0);
        chk("mrst_vid", vid_addr, 16'h0000);
        chk("mrst_v", mode_v, 0);
        chk("mrst_rate", rate, 0);
        chk("mrst_msize", mem_size, 0);
        chk("mrst_S_ty0", S, 3'd3);
        chk("mrst_ram", ram_addr, 16'hC000);
        cpu_addr = 16'h1234;
        #1;
        chk("mrst_ram_p1off", ram_addr, 16'h1234);

        @(negedge clk);
        reset = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
